// File: rtl/tlc_pkg.sv
// Shared types and constants for the four-approach traffic phase scheduler.
//   state_e     : scheduler phase (IDLE, GREEN, YELLOW, ALLRED)
//   NUM_APP     : number of approaches
//   LT_*        : 3-bit per-approach lamp codes
//   app_onehot  : approach id to one-hot approach mask
package tlc_pkg;

  localparam int unsigned NUM_APP = 4;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned LT_W    = 3;
  localparam int unsigned TMR_W   = 8;

  localparam logic [LT_W-1:0] LT_GREEN = 3'b001;
  localparam logic [LT_W-1:0] LT_YEL   = 3'b010;
  localparam logic [LT_W-1:0] LT_RED   = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YEL    = 2'd2,
    ST_ALLRED = 2'd3
  } state_e;

  // One-hot mask selecting a single approach.
  function automatic logic [NUM_APP-1:0] app_onehot(input logic [ID_W-1:0] id);
    app_onehot = NUM_APP'(1) << id;
  endfunction

endpackage

// File: rtl/tlc_rr_pick.sv
// Round-robin picker: first set bit of mask_i searching upward from ptr_i+1,
// wrapping modulo NUM_APP; ptr_i itself has the lowest priority.
//   mask_i  : candidate approaches
//   ptr_i   : last round-robin winner
//   valid_o : any candidate present
//   id_o    : winning approach (0 when valid_o=0)
module tlc_rr_pick
  import tlc_pkg::*;
(
  input  logic [NUM_APP-1:0] mask_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic               valid_o,
  output logic [ID_W-1:0]    id_o
);

  logic [ID_W-1:0] cand;

  // Scan farthest-first so the nearest candidate after ptr_i is the last write.
  always_comb begin
    valid_o = 1'b0;
    id_o    = '0;
    cand    = '0;
    for (int unsigned k = NUM_APP; k >= 1; k--) begin
      cand = ptr_i + ID_W'(k);
      if (mask_i[cand]) begin
        valid_o = 1'b1;
        id_o    = cand;
      end
    end
  end

endmodule

// File: rtl/tlc_phase_sched.sv
// Four-approach traffic signal phase scheduler with round-robin service.
// Phases: IDLE (all red) -> GREEN -> YELLOW -> ALLRED -> GREEN/IDLE.
// Optional feature macro: TLC_PREEMPT_EN adds a priority preemption request.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   ena                   : tick enable; nothing advances while low
//   req[3:0]              : per-approach vehicle sensor (level or pulse)
//   preempt_vld/_id       : (TLC_PREEMPT_EN only) preemption request
//   lights[11:0]          : 3-bit lamp code per approach, approach i at [3i+2:3i]
//   grant_id[1:0]         : approach in green or yellow, 0 otherwise
//   busy                  : high in GREEN, YELLOW or ALLRED
module tlc_phase_sched
  import tlc_pkg::*;
#(
  parameter int unsigned GREEN_MIN = 4,
  parameter int unsigned GREEN_MAX = 8,
  parameter int unsigned YEL_TICKS = 2,
  parameter int unsigned CLR_TICKS = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic [NUM_APP-1:0]      req,
`ifdef TLC_PREEMPT_EN
  input  logic                    preempt_vld,
  input  logic [ID_W-1:0]         preempt_id,
`endif
  output logic [LT_W*NUM_APP-1:0] lights,
  output logic [ID_W-1:0]         grant_id,
  output logic                    busy
);

  state_e                  state_q, state_d;
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic [NUM_APP-1:0]      pending_q, pending_d;
  logic [ID_W-1:0]         ptr_q, ptr_d;
  logic [ID_W-1:0]         grant_q, grant_d;
  logic [LT_W*NUM_APP-1:0] lights_q, lights_d;
  logic                    busy_q, busy_d;

  logic                    pre_vld;
  logic [ID_W-1:0]         pre_id;
  logic                    rr_vld;
  logic [ID_W-1:0]         rr_id;
  logic [NUM_APP-1:0]      green_mask;
  logic [NUM_APP-1:0]      enter_mask;
  logic                    start_green;
  logic                    other_wait;
  logic                    min_done;

`ifdef TLC_PREEMPT_EN
  assign pre_vld = preempt_vld;
  assign pre_id  = preempt_id;
`else
  assign pre_vld = 1'b0;
  assign pre_id  = '0;
`endif

  // Requests seen on this edge count as pending for arbitration.
  tlc_rr_pick u_rr_pick (
    .mask_i  (pending_q | req),
    .ptr_i   (ptr_q),
    .valid_o (rr_vld),
    .id_o    (rr_id)
  );

  assign green_mask = (state_q == ST_GREEN) ? app_onehot(grant_q) : '0;
  assign other_wait = |((pending_q | req) & ~green_mask);
  // GREEN_MAX is a ceiling on the minimum-green hold; with GREEN_MAX >= GREEN_MIN
  // the waiting-approach change always happens by GREEN_MIN.
  assign min_done   = (timer_q >= TMR_W'(GREEN_MIN)) || (timer_q >= TMR_W'(GREEN_MAX));

  // Next-state, timer, arbitration and pending bookkeeping.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    pending_d   = pending_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    start_green = 1'b0;
    enter_mask  = '0;

    if (ena) begin
      unique case (state_q)
        ST_IDLE: begin
          start_green = pre_vld || rr_vld;
        end
        ST_GREEN: begin
          if (pre_vld && (pre_id != grant_q)) begin
            state_d = ST_YEL;
            timer_d = TMR_W'(1);
          end else if (!pre_vld && other_wait && min_done) begin
            state_d = ST_YEL;
            timer_d = TMR_W'(1);
          end else if (timer_q != '1) begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
        ST_YEL: begin
          if (timer_q == TMR_W'(YEL_TICKS)) begin
            state_d = ST_ALLRED;
            timer_d = TMR_W'(1);
            grant_d = '0;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
        ST_ALLRED: begin
          if (timer_q == TMR_W'(CLR_TICKS)) begin
            if (pre_vld || rr_vld) begin
              start_green = 1'b1;
            end else begin
              state_d = ST_IDLE;
              timer_d = '0;
            end
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          timer_d = '0;
          grant_d = '0;
        end
      endcase

      // Preemption overrides round-robin and leaves the pointer untouched.
      if (start_green) begin
        state_d = ST_GREEN;
        timer_d = TMR_W'(1);
        if (pre_vld) begin
          grant_d = pre_id;
        end else begin
          grant_d = rr_id;
          ptr_d   = rr_id;
        end
        enter_mask = app_onehot(grant_d);
      end

      pending_d = (pending_q | (req & ~green_mask)) & ~enter_mask;
    end
  end

  // Output decode from next state so lamps are registered.
  always_comb begin
    lights_d = '0;
    for (int unsigned i = 0; i < NUM_APP; i++) begin
      lights_d[LT_W*i +: LT_W] = LT_RED;
      if (grant_d == ID_W'(i)) begin
        if (state_d == ST_GREEN) begin
          lights_d[LT_W*i +: LT_W] = LT_GREEN;
        end else if (state_d == ST_YEL) begin
          lights_d[LT_W*i +: LT_W] = LT_YEL;
        end
      end
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      pending_q <= '0;
      ptr_q     <= ID_W'(NUM_APP - 1);
      grant_q   <= '0;
      lights_q  <= {NUM_APP{LT_RED}};
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      lights_q  <= lights_d;
      busy_q    <= busy_d;
    end
  end

  assign lights   = lights_q;
  assign grant_id = grant_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_tlc_phase_sched.sv
// Self-checking bench for tlc_phase_sched: vector table, directed corner
// sequences and a randomized run against a phase-level reference model.
module tb_tlc_phase_sched;

  localparam int GMIN = 4;
  localparam int GMAX = 8;
  localparam int YEL  = 2;
  localparam int CLR  = 1;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic [3:0]  req;
  logic [11:0] lights;
  logic [1:0]  grant_id;
  logic        busy;
`ifdef TLC_PREEMPT_EN
  logic        preempt_vld;
  logic [1:0]  preempt_id;
`endif

  tlc_phase_sched #(
    .GREEN_MIN (GMIN),
    .GREEN_MAX (GMAX),
    .YEL_TICKS (YEL),
    .CLR_TICKS (CLR)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .req      (req),
`ifdef TLC_PREEMPT_EN
    .preempt_vld (preempt_vld),
    .preempt_id  (preempt_id),
`endif
    .lights   (lights),
    .grant_id (grant_id),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ena   = 1'b0;
    req   = '0;
`ifdef TLC_PREEMPT_EN
    preempt_vld = 1'b0;
    preempt_id  = '0;
`endif
    tick();
    tick();
    rst_n = 1'b1;
    ena   = 1'b1;
  endtask

  // Reference model: phase 0 idle, 1 green, 2 yellow, 3 all-red; cnt = enabled
  // cycles spent in the current phase including the current one.
  int       m_ph, m_app, m_cnt, m_ptr;
  bit [3:0] m_pend;

  function automatic void m_reset();
    m_ph = 0; m_app = 0; m_cnt = 0; m_ptr = 3; m_pend = '0;
  endfunction

  function automatic void m_grant(bit [3:0] eff);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (m_ptr + k) % 4;
      if (eff[c]) begin
        m_app = c; m_ptr = c; m_ph = 1; m_cnt = 1; m_pend[c] = 1'b0;
        return;
      end
    end
  endfunction

  function automatic void m_step(bit [3:0] r);
    bit [3:0] eff;
    bit       others;
    eff    = m_pend | r;
    others = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (r[i] && !(m_ph == 1 && m_app == i)) m_pend[i] = 1'b1;
      if (i != m_app && eff[i]) others = 1'b1;
    end
    case (m_ph)
      0: if (eff != 0) m_grant(eff);
      1: begin
        if (others && m_cnt >= GMIN) begin m_ph = 2; m_cnt = 1; end
        else if (m_cnt < 255) m_cnt++;
      end
      2: begin
        if (m_cnt == YEL) begin m_ph = 3; m_cnt = 1; end
        else m_cnt++;
      end
      default: begin
        if (m_cnt == CLR) begin
          if (eff != 0) m_grant(eff);
          else begin m_ph = 0; m_cnt = 0; end
        end else m_cnt++;
      end
    endcase
  endfunction

  function automatic logic [14:0] m_outs();
    logic [11:0] l;
    logic [1:0]  g;
    for (int i = 0; i < 4; i++) begin
      if (m_ph == 1 && m_app == i)      l[3*i +: 3] = 3'b001;
      else if (m_ph == 2 && m_app == i) l[3*i +: 3] = 3'b010;
      else                              l[3*i +: 3] = 3'b100;
    end
    g = (m_ph == 1 || m_ph == 2) ? 2'(m_app) : 2'd0;
    return {l, g, (m_ph != 0)};
  endfunction

  typedef struct {
    logic        ena;
    logic [3:0]  req;
    logic [11:0] lights;
    logic [1:0]  gid;
    logic        busy;
  } vec_t;

  vec_t tbl[18];

  initial begin
    int       order[$];
    int       gcnt[4];
    int       last;
    bit       seen;
    logic [2:0] gl;

    tbl[0]  = '{1'b1, 4'h0, 12'h924, 2'd0, 1'b0};
    tbl[1]  = '{1'b1, 4'h1, 12'h921, 2'd0, 1'b1};
    tbl[2]  = '{1'b1, 4'h4, 12'h921, 2'd0, 1'b1};
    tbl[3]  = '{1'b1, 4'h0, 12'h921, 2'd0, 1'b1};
    tbl[4]  = '{1'b1, 4'h0, 12'h921, 2'd0, 1'b1};
    tbl[5]  = '{1'b1, 4'h0, 12'h922, 2'd0, 1'b1};
    tbl[6]  = '{1'b1, 4'h0, 12'h922, 2'd0, 1'b1};
    tbl[7]  = '{1'b1, 4'h0, 12'h924, 2'd0, 1'b1};
    tbl[8]  = '{1'b1, 4'h0, 12'h864, 2'd2, 1'b1};
    tbl[9]  = '{1'b0, 4'h1, 12'h864, 2'd2, 1'b1};
    tbl[10] = '{1'b1, 4'h0, 12'h864, 2'd2, 1'b1};
    tbl[11] = '{1'b1, 4'h8, 12'h864, 2'd2, 1'b1};
    tbl[12] = '{1'b1, 4'h0, 12'h864, 2'd2, 1'b1};
    tbl[13] = '{1'b1, 4'h0, 12'h8A4, 2'd2, 1'b1};
    tbl[14] = '{1'b1, 4'h0, 12'h8A4, 2'd2, 1'b1};
    tbl[15] = '{1'b1, 4'h0, 12'h924, 2'd0, 1'b1};
    tbl[16] = '{1'b1, 4'h0, 12'h324, 2'd3, 1'b1};
    tbl[17] = '{1'b1, 4'h0, 12'h324, 2'd3, 1'b1};

    // Asynchronous reset values before any clock edge.
    rst_n = 1'b1; ena = 1'b0; req = '0;
`ifdef TLC_PREEMPT_EN
    preempt_vld = 1'b0; preempt_id = '0;
`endif
    #2 rst_n = 1'b0;
    #1;
    chk("rst_lights", 32'(lights), 32'h924);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_busy", 32'(busy), 0);
    tick();
    rst_n = 1'b1; ena = 1'b1;

    // Idle with no requests.
    for (int n = 0; n < 20; n++) begin
      tick();
      chk("idle20", {19'd0, lights, busy}, {19'd0, 12'h924, 1'b0});
    end

    // Vector table.
    do_reset();
    for (int v = 0; v < 18; v++) begin
      ena = tbl[v].ena;
      req = tbl[v].req;
      tick();
      chk($sformatf("vec%0d", v), {17'd0, lights, grant_id, busy},
          {17'd0, tbl[v].lights, tbl[v].gid, tbl[v].busy});
    end
    req = '0;

    // Pulse on approach 0 holds green indefinitely; timer saturation does not
    // disturb the change once another approach arrives at green cycle 257.
    do_reset();
    req = 4'h1;
    tick();
    chk("hold_c1", 32'(lights), 32'h921);
    req = '0;
    for (int n = 0; n < 256; n++) begin
      tick();
      chk(n < 50 ? "hold50" : "hold_long", {18'd0, lights, grant_id}, {18'd0, 12'h921, 2'd0});
    end
    req = 4'h2;
    tick();
    chk("sat_yel", 32'(lights), 32'h922);
    req = '0;

    // Three waiting approaches are served in round-robin order.
    do_reset();
    order.delete();
    gcnt = '{default: 0};
    last = -1;
    for (int n = 0; n < 40; n++) begin
      req = (n == 0) ? 4'h1 : (n == 1) ? 4'hE : 4'h0;
      tick();
      gl = lights[3*grant_id +: 3];
      if (busy && gl == 3'b001) begin
        gcnt[grant_id]++;
        if (int'(grant_id) != last) begin
          order.push_back(int'(grant_id));
          last = int'(grant_id);
        end
      end
    end
    chk("rr_cnt", 32'(order.size()), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < order.size()) chk($sformatf("rr_order%0d", i), 32'(order[i]), 32'(i));
    end
    for (int i = 0; i < 3; i++) chk($sformatf("rr_glen%0d", i), 32'(gcnt[i]), 4);
    chk("rr_g3_held", 32'(gcnt[3] >= 4), 1);

    // Enable dropped during the first yellow cycle freezes everything.
    do_reset();
    req = 4'h3;
    tick();
    req = '0;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      if (lights[2:0] == 3'b010) seen = 1'b1;
      else tick();
    end
    chk("yel_wait", 32'(seen), 1);
    ena = 1'b0;
    for (int n = 0; n < 10; n++) begin
      tick();
      chk("frz", {18'd0, lights, grant_id}, {18'd0, 12'h922, 2'd0});
    end
    ena = 1'b1;
    tick();
    chk("yel_last", 32'(lights), 32'h922);
    tick();
    chk("frz_allred", 32'(lights), 32'h924);
    tick();
    chk("frz_next", {18'd0, lights, grant_id}, {18'd0, 12'h90C, 2'd1});

    // Reset mid-green: phase abandoned without yellow, pending discarded.
    do_reset();
    req = 4'h1;
    tick();
    req = 4'h4;
    tick();
    req = '0;
    rst_n = 1'b0;
    #1;
    chk("midrst", {17'd0, lights, grant_id, busy}, {17'd0, 12'h924, 2'd0, 1'b0});
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      chk("post_rst", {19'd0, lights, busy}, {19'd0, 12'h924, 1'b0});
    end

`ifdef TLC_PREEMPT_EN
    // Preemption cuts green short, holds its own green, leaves RR pointer alone.
    do_reset();
    req = 4'h1;
    tick();
    chk("pre_g0", 32'(lights), 32'h921);
    req = '0;
    preempt_vld = 1'b1; preempt_id = 2'd3;
    tick();
    chk("pre_yel", 32'(lights), 32'h922);
    tick();
    chk("pre_yel2", 32'(lights), 32'h922);
    tick();
    chk("pre_clr", 32'(lights), 32'h924);
    tick();
    chk("pre_g3", {18'd0, lights, grant_id}, {18'd0, 12'h324, 2'd3});
    req = 4'h2;
    tick();
    req = '0;
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("pre_hold", 32'(lights), 32'h324);
    end
    preempt_vld = 1'b0;
    tick();
    chk("pre_drop_yel", 32'(lights), 32'h524);
    tick();
    tick();
    chk("pre_drop_clr", 32'(lights), 32'h924);
    tick();
    chk("pre_next_rr", {18'd0, lights, grant_id}, {18'd0, 12'h90C, 2'd1});
`endif

    // Randomized run against the reference model, with one reset mid-run.
    do_reset();
    m_reset();
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        do_reset();
        m_reset();
      end
      ena = ($urandom_range(9) != 0);
      req = '0;
      for (int i = 0; i < 4; i++) begin
        if ((n % 600) < 300) req[i] = ($urandom_range(5) == 0);
        else                 req[i] = ($urandom_range(199) == 0);
      end
      if (ena) m_step(req);
      tick();
      chk("rand", {17'd0, lights, grant_id, busy}, {17'd0, m_outs()});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
